circle_drawer: RTL and testbench
================================

Name: circle_drawer

Overview:
- Midpoint (Bresenham) circle rasteriser. Same slot as the screen-fill engine: sits between the top-level control logic and the 160x120 VGA adapter.
- Emits one pixel per clock on the vga_x/vga_y/vga_colour/vga_plot bus, drawing the outline of a circle of given centre, radius and colour.
- Uses the start/done level handshake shared by all drawing engines.
- Pixels outside the visible screen are clipped by suppressing vga_plot.

Parameters:
SCREEN_W, 160, visible width in pixels; x valid range 0..SCREEN_W-1
SCREEN_H, 120, visible height in pixels; y valid range 0..SCREEN_H-1

Ports:
clk  input  1  system clock (CLOCK_50 domain)
rst  input  1  synchronous reset, active-high
start  input  1  level request; held high until done seen
centre_x  input  8  circle centre x, unsigned
centre_y  input  7  circle centre y, unsigned
radius  input  8  radius in pixels, unsigned, 0..255
colour  input  3  pixel colour
done  output  1  drawing complete; held until start drops
vga_x  output  8  pixel x
vga_y  output  7  pixel y
vga_colour  output  3  pixel colour
vga_plot  output  1  write-enable to the adapter, one pixel per cycle

Behaviour:
- Reset: every output is 0 and the state is IDLE. The rst clock edge overrides all other activity, including reset mid-draw; no further plots are issued after that edge.
- States and transitions:
  - IDLE: done=0, vga_plot=0. When start=1 is sampled, latch centre_x/centre_y/radius/colour and go to INIT. Later input changes are ignored until the next IDLE.
  - INIT: one cycle. ox=radius, oy=0, crit=1-radius; vga_plot=0. Go to PLOT with octant=0.
  - PLOT: octant counter 0..7, one candidate pixel per cycle, in this order:
    (cx+ox,cy+oy), (cx+oy,cy+ox), (cx-ox,cy+oy), (cx-oy,cy+ox), (cx-ox,cy-oy), (cx-oy,cy-ox), (cx+ox,cy-oy), (cx+oy,cy-ox).
  - On the octant=7 cycle, update the loop variables:
    - oy<=oy+1.
    - If crit<=0: crit<=crit+2*(oy+1)+1.
    - Else: ox<=ox-1, crit<=crit+2*((oy+1)-(ox-1))+1.
    - If the updated oy > updated ox, go to DONE. Otherwise octant<=0 and stay in PLOT.
  - DONE: done=1, vga_plot=0. When start=0 is sampled, go to IDLE; done falls the following cycle.
- Arithmetic widths:
  - Coordinates are computed as 10-bit signed values.
  - crit is 11-bit signed.
  - ox and oy are 8-bit unsigned, with the compare done at 9 bits.
- Clipping: vga_plot=1 only in PLOT and only when 0<=x<SCREEN_W and 0<=y<SCREEN_H. Clipped cycles have vga_plot=0 and still consume their cycle. vga_x/vga_y are the low bits of the computed coordinate and are don't-care when vga_plot=0.
- vga_x, vga_y, vga_colour and vga_plot are registered, so they are valid in the same cycle as the corresponding state.
- Latency for N loop iterations: start sampled at edge 0, INIT after edge 0, plots during edges 1..8N, done=1 after edge 8N+1.
- Duplicate pixels (octant overlap at oy=0 and oy=ox) are plotted, not filtered.
- start dropping mid-draw is ignored; drawing runs to DONE, then returns to IDLE immediately.
- A new request needs start low for at least one cycle in IDLE.

Decomposition:
- Package circle_pkg holds:
  - the state enum (IDLE, INIT, PLOT, DONE);
  - SCREEN_W_DEF=160 and SCREEN_H_DEF=120;
  - the 10-bit signed coordinate typedef and the 11-bit crit typedef.
- One combinational sub-module, circle_octant_point: inputs octant, cx, cy, ox, oy; outputs 10-bit signed x and y plus an in_bounds flag. The FSM and datapath stay in circle_drawer.

Test Plan:
- Reset then r=0, centre (80,60), colour 3'b010, start held:
  - exactly 8 plot cycles, all at (80,60), colour 010;
  - done rises after edge 9 and falls one cycle after start drops.
- r=1, centre (80,60):
  - 16 plot cycles in the specified octant order;
  - the first 8 are (81,60),(80,61),(79,60),(80,61),(79,60),(80,59),(81,60),(80,59);
  - done after edge 17.
- r=30, centre (80,60):
  - every plotted (x,y) satisfies |(x-80)^2+(y-60)^2-900| <= 60;
  - all 8 octants are symmetric;
  - no pixel is off-screen;
  - the plot count is a multiple of 8.
- Clipping, centre (0,0), r=10:
  - no plot with negative coordinates;
  - plotted set equals the x>=0, y>=0 subset of the r=10 golden model;
  - cycle count identical to the unclipped r=10 case.
- Assert rst mid-draw (r=50):
  - vga_plot=0 and done=0 from the next cycle;
  - a fresh start afterwards draws a full, correct circle.
- Change centre/radius while drawing, and drop start early:
  - output matches the originally latched circle;
  - done pulses for one cycle, then IDLE.

Source files
------------

// File: rtl/circle_pkg.sv
// Shared types and constants for the midpoint circle rasteriser.
package circle_pkg;

    // Drawing engine states; ST_IDLE must stay at encoding 0 (reset value).
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_PLOT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;

    // Screen coordinates before clipping can be negative or exceed 255.
    typedef logic signed [9:0]  coord_t;
    // Midpoint decision variable.
    typedef logic signed [10:0] crit_t;

endpackage

// File: rtl/circle_drawer_if.sv
// Request and pixel bus between the control logic, the circle engine and the VGA adapter.
//
// Handshake: start is a level request. The engine latches centre/radius/colour on
// the first cycle it samples start=1 while idle, and ignores them afterwards.
// done rises when the outline is finished and stays high until start is sampled
// low; the requester must then hold start low for at least one idle cycle before
// asking again. vga_plot qualifies vga_x/vga_y/vga_colour for exactly one pixel
// per cycle; the address lines are meaningless while vga_plot=0.
interface circle_drawer_if import circle_pkg::*; ();
    logic       start;
    logic [7:0] centre_x;
    logic [6:0] centre_y;
    logic [7:0] radius;
    logic [2:0] colour;
    logic       done;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    state_t     dbg_state;

    modport master (
        output start, centre_x, centre_y, radius, colour,
        input  done, vga_x, vga_y, vga_colour, vga_plot, dbg_state
    );

    modport slave (
        input  start, centre_x, centre_y, radius, colour,
        output done, vga_x, vga_y, vga_colour, vga_plot, dbg_state
    );
endinterface

// File: rtl/circle_octant_point.sv
// Maps one octant of the current (ox, oy) step to a screen pixel and flags
// whether it lands on the visible screen.
module circle_octant_point import circle_pkg::*; #(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic [2:0] octant_i,
    input  logic [7:0] cx_i,
    input  logic [6:0] cy_i,
    input  logic [7:0] ox_i,
    input  logic [7:0] oy_i,
    output coord_t     x_o,
    output coord_t     y_o,
    output logic       in_bounds_o
);

    coord_t cx, cy, ox, oy;

    // Select the reflected point for this octant, then clip against the screen.
    always_comb begin
        cx = {2'b00, cx_i};
        cy = {3'b000, cy_i};
        ox = {2'b00, ox_i};
        oy = {2'b00, oy_i};
        x_o = cx + ox;
        y_o = cy + oy;
        case (octant_i)
            3'd0: begin x_o = cx + ox; y_o = cy + oy; end
            3'd1: begin x_o = cx + oy; y_o = cy + ox; end
            3'd2: begin x_o = cx - ox; y_o = cy + oy; end
            3'd3: begin x_o = cx - oy; y_o = cy + ox; end
            3'd4: begin x_o = cx - ox; y_o = cy - oy; end
            3'd5: begin x_o = cx - oy; y_o = cy - ox; end
            3'd6: begin x_o = cx + ox; y_o = cy - oy; end
            3'd7: begin x_o = cx + oy; y_o = cy - ox; end
            default: begin x_o = cx; y_o = cy; end
        endcase
        in_bounds_o = !x_o[9] && !y_o[9]
                      && (x_o < coord_t'(SCREEN_W))
                      && (y_o < coord_t'(SCREEN_H));
    end

endmodule

// File: rtl/circle_drawer.sv
// Midpoint circle rasteriser: one candidate outline pixel per clock on the VGA bus.
module circle_drawer import circle_pkg::*; #(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic           clk,
    input  logic           rst,
    circle_drawer_if.slave bus
);

    state_t            state_q, state_d;
    logic [2:0]        octant_q, octant_d;
    logic [7:0]        ox_q, ox_d, oy_q, oy_d;
    crit_t             crit_q, crit_d;
    logic [7:0]        cx_q, cx_d, r_q, r_d;
    logic [6:0]        cy_q, cy_d;
    logic [2:0]        col_q, col_d;
    logic              done_q, done_d, plot_q, plot_d;
    logic [7:0]        vga_x_q, vga_x_d;
    logic [6:0]        vga_y_q, vga_y_d;
    logic [2:0]        vga_col_q, vga_col_d;

    logic              crit_le0;
    logic [8:0]        oy_n9;
    logic signed [8:0] ox_n9;
    crit_t             oy_n11, ox_n11;
    coord_t            pt_x, pt_y;
    logic              pt_in;

    // The point is computed from next-state values so the registered pixel
    // lines up with the PLOT/octant state it belongs to.
    circle_octant_point #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_point (
        .octant_i    (octant_d),
        .cx_i        (cx_q),
        .cy_i        (cy_q),
        .ox_i        (ox_d),
        .oy_i        (oy_d),
        .x_o         (pt_x),
        .y_o         (pt_y),
        .in_bounds_o (pt_in)
    );

    // Next-state, midpoint step and registered-output decode.
    always_comb begin
        state_d  = state_q;
        octant_d = octant_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        crit_d   = crit_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        r_d      = r_q;
        col_d    = col_q;

        // Candidate loop variables for the end of an 8-octant group. ox can
        // step below zero (radius 0), so it is carried as 9-bit signed.
        crit_le0 = crit_q[10] || (crit_q == '0);
        oy_n9    = {1'b0, oy_q} + 9'd1;
        ox_n9    = crit_le0 ? $signed({1'b0, ox_q}) : $signed({1'b0, ox_q}) - 9'sd1;
        oy_n11   = {2'b00, oy_n9};
        ox_n11   = {{2{ox_n9[8]}}, ox_n9};

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    cx_d    = bus.centre_x;
                    cy_d    = bus.centre_y;
                    r_d     = bus.radius;
                    col_d   = bus.colour;
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                ox_d     = r_q;
                oy_d     = 8'd0;
                crit_d   = 11'sd1 - crit_t'({3'b000, r_q});
                octant_d = 3'd0;
                state_d  = ST_PLOT;
            end
            ST_PLOT: begin
                if (octant_q != 3'd7) begin
                    octant_d = octant_q + 3'd1;
                end else begin
                    oy_d = oy_n9[7:0];
                    ox_d = ox_n9[7:0];
                    if (crit_le0) crit_d = crit_q + (oy_n11 <<< 1) + 11'sd1;
                    else          crit_d = crit_q + ((oy_n11 - ox_n11) <<< 1) + 11'sd1;
                    if ($signed(oy_n9) > ox_n9) begin
                        state_d = ST_DONE;
                    end else begin
                        octant_d = 3'd0;
                    end
                end
            end
            ST_DONE: begin
                if (!bus.start) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // High coordinate bits are also required clear so the truncated
        // bus address can never alias an off-screen point.
        plot_d    = (state_d == ST_PLOT) && pt_in
                    && (pt_x[9:8] == 2'b00) && (pt_y[9:7] == 3'b000);
        vga_x_d   = pt_x[7:0];
        vga_y_d   = pt_y[6:0];
        vga_col_d = (state_d == ST_PLOT) ? col_q : 3'd0;
        done_d    = (state_d == ST_DONE);
    end

    // State, datapath and output registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            octant_q  <= 3'd0;
            ox_q      <= 8'd0;
            oy_q      <= 8'd0;
            crit_q    <= '0;
            cx_q      <= 8'd0;
            cy_q      <= 7'd0;
            r_q       <= 8'd0;
            col_q     <= 3'd0;
            done_q    <= 1'b0;
            plot_q    <= 1'b0;
            vga_x_q   <= 8'd0;
            vga_y_q   <= 7'd0;
            vga_col_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            octant_q  <= octant_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            crit_q    <= crit_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            r_q       <= r_d;
            col_q     <= col_d;
            done_q    <= done_d;
            plot_q    <= plot_d;
            vga_x_q   <= vga_x_d;
            vga_y_q   <= vga_y_d;
            vga_col_q <= vga_col_d;
        end
    end

    assign bus.done       = done_q;
    assign bus.vga_plot   = plot_q;
    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_col_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_circle_drawer.sv
// Self-checking bench for circle_drawer: per-cycle scoreboard against a
// behavioural outline model, plus hand-computed pins and geometric properties.
module tb_circle_drawer;
    import circle_pkg::*;

    localparam int W = 20;  // {done, plot, x[7:0], y[6:0], colour[2:0]}

    logic clk = 1'b0;
    logic rst = 1'b1;

    circle_drawer_if bus();

    circle_drawer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // ---------------- scoreboard state ----------------
    int check_cnt = 0;
    int pass_cnt  = 0;
    logic [W-1:0] exp_q[$];
    int m_x[$], m_y[$];          // model pixel sequence
    int plot_x[$], plot_y[$];    // pixels the DUT actually plotted
    int done_at = -1;
    int edge0   = 0;
    logic done_prev = 1'b0;
    bit seen[160][120];

    task automatic check(input string name, input int got, input int exp);
        check_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask

    function automatic logic on_screen(input int x, input int y);
        return (x >= 0) && (x < 160) && (y >= 0) && (y < 120);
    endfunction

    // Behavioural outline: the midpoint loop in plain integers, 8 reflections
    // per step in the required octant order.
    task automatic build_model(input int cx, input int cy, input int r, output int n_iter);
        int ox, oy, crit;
        int px[8], py[8];
        ox = r; oy = 0; crit = 1 - r; n_iter = 0;
        m_x.delete(); m_y.delete();
        do begin
            px = '{cx+ox, cx+oy, cx-ox, cx-oy, cx-ox, cx-oy, cx+ox, cx+oy};
            py = '{cy+oy, cy+ox, cy+oy, cy+ox, cy-oy, cy-ox, cy-oy, cy-ox};
            for (int k = 0; k < 8; k++) begin
                m_x.push_back(px[k]);
                m_y.push_back(py[k]);
            end
            n_iter++;
            oy++;
            if (crit <= 0) crit += 2 * oy + 1;
            else begin
                ox--;
                crit += 2 * (oy - ox) + 1;
            end
        end while (oy <= ox);
    endtask

    // ---------------- compare process ----------------
    always @(posedge clk) begin
        logic [W-1:0] e, g;
        #2;
        g = {bus.done, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour};
        if (bus.vga_plot) begin
            plot_x.push_back(int'(bus.vga_x));
            plot_y.push_back(int'(bus.vga_y));
        end
        if (bus.done && !done_prev) done_at = edge_cnt;
        done_prev = bus.done;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_cnt++;
            if ((e[19:18] == g[19:18]) && (!e[18] || (e[17:0] == g[17:0]))) pass_cnt++;
            else $display("FAIL cycle %0d: got done=%0b plot=%0b x=%0d y=%0d c=%0d, expected done=%0b plot=%0b x=%0d y=%0d c=%0d",
                          edge_cnt - edge0, g[19], g[18], g[17:10], g[9:3], g[2:0],
                          e[19], e[18], e[17:10], e[9:3], e[2:0]);
        end
    end

    // ---------------- driver ----------------
    // early>0: drop start (and scramble the inputs) that many cycles after the
    // request; otherwise hold start 'hold' extra cycles after done appears.
    task automatic run_draw(input int cx, input int cy, input int r, input int col,
                            input int early, input int hold, output int n);
        int d, done_cycles, guard, xi, yi;
        logic on;
        build_model(cx, cy, r, n);
        plot_x.delete(); plot_y.delete();
        done_at = -1;
        @(negedge clk);
        bus.centre_x = 8'(cx);
        bus.centre_y = 7'(cy);
        bus.radius   = 8'(r);
        bus.colour   = 3'(col);
        bus.start    = 1'b1;
        edge0 = edge_cnt + 1;
        exp_q.push_back('0);                       // INIT cycle
        for (int i = 0; i < m_x.size(); i++) begin
            xi = m_x[i]; yi = m_y[i];
            on = on_screen(xi, yi);
            exp_q.push_back({1'b0, on, xi[7:0], yi[6:0], 3'(col)});
        end
        d = (early > 0) ? early : 8 * n + 2 + hold;
        done_cycles = (d - 8 * n - 1 > 1) ? d - 8 * n - 1 : 1;
        repeat (done_cycles) exp_q.push_back({1'b1, 1'b0, 18'd0});
        exp_q.push_back('0);                       // back in IDLE
        repeat (d) @(negedge clk);
        bus.start = 1'b0;
        if (early > 0) begin
            bus.centre_x = 8'(cx + 37);
            bus.centre_y = 7'(cy + 11);
            bus.radius   = 8'(r + 9);
            bus.colour   = ~3'(col);
        end
        guard = 0;
        while (exp_q.size() > 0 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        check("queue drained", exp_q.size(), 0);
        exp_q.delete();
        check("done edge", done_at - edge0, 8 * n + 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, bad, asym, onscr, k10, cnt10, dx, dy;
        int lit_x[8], lit_y[8];
        lit_x = '{81, 80, 79, 80, 79, 80, 81, 80};
        lit_y = '{60, 61, 60, 61, 60, 59, 60, 59};

        bus.start = 1'b0; bus.centre_x = 8'd0; bus.centre_y = 7'd0;
        bus.radius = 8'd0; bus.colour = 3'd0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset done", int'(bus.done), 0);
        check("reset plot", int'(bus.vga_plot), 0);
        check("reset x", int'(bus.vga_x), 0);
        check("reset y", int'(bus.vga_y), 0);
        check("reset colour", int'(bus.vga_colour), 0);
        check("reset state", int'(bus.dbg_state), int'(ST_IDLE));
        rst = 1'b0;
        @(negedge clk);

        // r=0: eight plots at the centre, done after edge 9
        run_draw(80, 60, 0, 3'b010, 0, 2, n);
        check("r0 plot count", plot_x.size(), 8);
        bad = 0;
        foreach (plot_x[i]) if (plot_x[i] != 80 || plot_y[i] != 60) bad++;
        check("r0 all at centre", bad, 0);
        check("r0 done edge literal", done_at - edge0, 9);

        // r=1: 16 plots, first group pinned by hand
        run_draw(80, 60, 1, 3'b111, 0, 0, n);
        check("r1 plot count", plot_x.size(), 16);
        check("r1 done edge literal", done_at - edge0, 17);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (m_x[i] != lit_x[i] || m_y[i] != lit_y[i]) bad++;
            if (plot_x.size() > i && (plot_x[i] != lit_x[i] || plot_y[i] != lit_y[i])) bad++;
        end
        check("r1 first octant group", bad, 0);

        // r=30: geometric properties of what was plotted
        run_draw(80, 60, 30, 3'b001, 0, 1, n);
        check("r30 count multiple of 8", plot_x.size() % 8, 0);
        check("r30 count vs model", plot_x.size(), m_x.size());
        for (int x = 0; x < 160; x++) for (int y = 0; y < 120; y++) seen[x][y] = 1'b0;
        bad = 0;
        foreach (plot_x[i]) begin
            if (!on_screen(plot_x[i], plot_y[i])) bad++;
            else seen[plot_x[i]][plot_y[i]] = 1'b1;
        end
        check("r30 on screen", bad, 0);
        bad = 0; asym = 0;
        foreach (plot_x[i]) begin
            dx = plot_x[i] - 80; dy = plot_y[i] - 60;
            if (dx * dx + dy * dy - 900 > 60 || 900 - dx * dx - dy * dy > 60) bad++;
            if (dx < -30 || dx > 30 || dy < -30 || dy > 30) asym++;
            else if (!seen[80 + dy][60 + dx] || !seen[80 - dx][60 + dy] || !seen[80 + dx][60 - dy]) asym++;
        end
        check("r30 radius error", bad, 0);
        check("r30 symmetry", asym, 0);

        // Clipping: r=10 unclipped reference, then centred at the origin
        run_draw(80, 60, 10, 3'b100, 0, 0, n);
        k10 = done_at - edge0;
        cnt10 = plot_x.size();
        check("r10 count", cnt10, 8 * n);
        run_draw(0, 0, 10, 3'b100, 0, 0, n);
        check("clip done edge same as unclipped", done_at - edge0, k10);
        onscr = 0;
        foreach (m_x[i]) if (on_screen(m_x[i], m_y[i])) onscr++;
        check("clip plot count", plot_x.size(), onscr);
        bad = 0;
        foreach (plot_x[i]) if (!on_screen(plot_x[i], plot_y[i])) bad++;
        check("clip no off-screen", bad, 0);

        // Reset in the middle of an r=50 draw
        build_model(80, 60, 50, n);
        @(negedge clk);
        bus.centre_x = 8'd80; bus.centre_y = 7'd60; bus.radius = 8'd50;
        bus.colour = 3'b011; bus.start = 1'b1;
        edge0 = edge_cnt + 1;
        exp_q.push_back('0);
        for (int i = 0; i < 19; i++)
            exp_q.push_back({1'b0, 1'b1, 8'(m_x[i]), 7'(m_y[i]), 3'b011});
        repeat (20) @(negedge clk);
        check("pre-reset queue consumed", exp_q.size(), 0);
        exp_q.delete();
        repeat (3) exp_q.push_back('0);
        rst = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post-reset state", int'(bus.dbg_state), int'(ST_IDLE));
        exp_q.delete();
        run_draw(80, 60, 50, 3'b011, 0, 0, n);
        check("r50 full count", plot_x.size(), 8 * n);

        // Inputs scrambled and start dropped early: original circle, one-cycle done
        run_draw(60, 50, 20, 3'b101, 5, 0, n);
        check("early drop count", plot_x.size(), 8 * n);
        check("early drop idle", int'(bus.dbg_state), int'(ST_IDLE));
        check("early drop done low", int'(bus.done), 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        check_cnt++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
